// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: performs WIDTH-bit additions one nibble per cycle on an
// external registered 4-bit CLA slice. The carry from the slice is fed back
// into its Cin. Operands arrive on a valid/ready request handshake, and the
// sum/carry leave on a valid/ready response handshake.
module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  // response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  // shared CLA slice
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_cout
);

  localparam int NIB = WIDTH / 4;
  // k runs 0..NIB: NIB issue cycles plus one final cycle to collect the
  // last registered nibble returned by the slice.
  localparam int K_W = $clog2(NIB + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Nibble views of the latched operands. They let the issue mux below
  // select a 4-bit group by counter value.
  logic [3:0] a_nib [NIB];
  logic [3:0] b_nib [NIB];

  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    assign a_nib[gi] = a_q[4*gi +: 4];
    assign b_nib[gi] = b_q[4*gi +: 4];
  end

  // Next-state, datapath capture and handshake/slice outputs.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is held low while reset is applied, even though the
        // state register already reads IDLE.
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_cin;
          k_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Issue nibble k to the slice. Past the last nibble, drive zeros.
        for (int i = 0; i < NIB; i++) begin
          if (k_q == K_W'(i)) begin
            slice_a = a_nib[i];
            slice_b = b_nib[i];
          end
        end

        // The first nibble takes the request's carry. Later nibbles take
        // the slice's registered carry-out from the previous nibble
        // directly. This forward is the combinational critical path.
        if (k_q == '0) begin
          slice_cin = cin_q;
        end else if (k_q < K_W'(NIB)) begin
          slice_cin = slice_cout;
        end

        // The slice result for nibble k-1 is available during cycle k.
        for (int i = 0; i < NIB; i++) begin
          if (k_q == K_W'(i + 1)) begin
            sum_d[4*i +: 4] = slice_s;
          end
        end

        if (k_q == K_W'(NIB)) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end

      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. A synchronous reset discards any
  // in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Testbench for cla_seq_ctrl. It drives a WIDTH=16 instance and a WIDTH=4
// instance, each paired with a behavioural registered 4-bit CLA slice.
module tb_cla_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Common stimulus, steered to one DUT by sel4.
  logic        sel4;
  logic        req_valid;
  logic [15:0] req_a, req_b;
  logic        req_cin;
  logic        rsp_ready;

  // WIDTH=16 instance signals
  logic        r16_ready, v16, c16, sc16, sl16_co;
  logic [15:0] sum16;
  logic [3:0]  sa16, sb16, sl16_s;

  // WIDTH=4 instance signals
  logic        r4_ready, v4, c4, sc4, sl4_co;
  logic [3:0]  sum4;
  logic [3:0]  sa4, sb4, sl4_s;

  cla_seq_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel4), .req_ready(r16_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(v16), .rsp_ready(rsp_ready & ~sel4),
    .rsp_sum(sum16), .rsp_cout(c16),
    .slice_a(sa16), .slice_b(sb16), .slice_cin(sc16),
    .slice_s(sl16_s), .slice_cout(sl16_co)
  );

  cla_seq_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel4), .req_ready(r4_ready),
    .req_a(req_a[3:0]), .req_b(req_b[3:0]), .req_cin(req_cin),
    .rsp_valid(v4), .rsp_ready(rsp_ready & sel4),
    .rsp_sum(sum4), .rsp_cout(c4),
    .slice_a(sa4), .slice_b(sb4), .slice_cin(sc4),
    .slice_s(sl4_s), .slice_cout(sl4_co)
  );

  // Registered CLA slice models: the result appears one cycle after the
  // operands are presented.
  always @(posedge clk) begin
    if (!rst_n) begin
      {sl16_co, sl16_s} <= 5'd0;
      {sl4_co, sl4_s}   <= 5'd0;
    end else begin
      {sl16_co, sl16_s} <= {1'b0, sa16} + {1'b0, sb16} + {4'd0, sc16};
      {sl4_co, sl4_s}   <= {1'b0, sa4} + {1'b0, sb4} + {4'd0, sc4};
    end
  end

  // Observed outputs of the selected DUT.
  logic        o_ready, o_valid, o_cout;
  logic [15:0] o_sum;
  assign o_ready = sel4 ? r4_ready : r16_ready;
  assign o_valid = sel4 ? v4 : v16;
  assign o_cout  = sel4 ? c4 : c16;
  assign o_sum   = sel4 ? {12'd0, sum4} : sum16;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Waits for rsp_valid at falling edges, with a bounded wait, and returns
  // the number of edges seen since the acceptance edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Runs one full transaction. The task is entered at a falling edge with
  // the DUT in IDLE, and it leaves at the falling edge after the response
  // handshake, with the DUT back in IDLE.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] es, input logic ec, input int hold,
                         input string nm);
    int lat;
    int nib;
    nib = sel4 ? 1 : 4;
    chk({nm, " ready_idle"}, 32'(o_ready), 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin;
    @(negedge clk);
    // Operands must be latched at acceptance; scramble the inputs afterwards.
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_cin = ~cin;
    chk({nm, " ready_run"}, 32'(o_ready), 32'd0);
    wait_rsp(lat);
    chk({nm, " latency"}, 32'(lat), 32'(nib + 1));
    chk({nm, " sum"}, 32'(o_sum), 32'(es));
    chk({nm, " cout"}, 32'(o_cout), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " hold"}, {14'd0, o_valid, o_ready, o_cout, o_sum}, {14'd0, 1'b1, 1'b0, ec, es});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, " valid_drop"}, 32'(o_valid), 32'd0);
    $display("txn %s: a=0x%0h b=0x%0h cin=%0d -> sum=0x%0h cout=%0d lat=%0d",
             nm, a, b, cin, es, ec, lat);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    int          hold;
    string       nm;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int vcnt;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, "1234+4321"};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, "FFFF+0001"};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, "FFFF+FFFF+1"};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, "0000+0000"};
    vecs[4] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 3, "backpressure"};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 0, "0F0F+00F1+1"};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0, "8000+8000"};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1, "ABCD+1111"};

    sel4 = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0;
    rsp_ready = 1'b0;

    // Reset values for both instances
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst16 outputs", {9'd0, r16_ready, v16, c16, sc16, sa16, sb16, sum16},
        {9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'd0});
    chk("rst4 outputs", {13'd0, r4_ready, v4, c4, sc4, sa4, sb4, sum4}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready after reset", {30'd0, r16_ready, r4_ready}, 32'd3);
    @(negedge clk);

    // Table-driven transactions on the 16-bit instance, issued back to back
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
              vecs[i].hold, vecs[i].nm);
    end

    // A request held through the response handshake is ignored in that
    // cycle and accepted in the following IDLE cycle.
    req_valid = 1'b1; req_a = 16'hFFFF; req_b = 16'hFFFF; req_cin = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("b2b first latency", 32'(lat), 32'd5);
    chk("b2b first result", {15'd0, o_cout, o_sum}, {15'd0, 1'b1, 16'hFFFF});
    rsp_ready = 1'b1; req_valid = 1'b1; req_a = 16'h0000; req_b = 16'h0000; req_cin = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b handshake ignores req", {30'd0, o_valid, o_ready}, {30'd0, 1'b0, 1'b1});
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b accepted in idle", 32'(o_ready), 32'd0);
    wait_rsp(lat);
    chk("b2b second latency", 32'(lat), 32'd5);
    chk("b2b second result", {15'd0, o_cout, o_sum}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("txn b2b: FFFF+FFFF+1 then 0000+0000 with req held through handshake");

    // Reset asserted during RUN at k=2
    req_valid = 1'b1; req_a = 16'h1111; req_b = 16'h2222; req_cin = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst outputs", {9'd0, r16_ready, v16, c16, sc16, sa16, sb16, sum16}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst ready after release", 32'(r16_ready), 32'd1);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (v16) vcnt++;
    end
    chk("midrst no rsp_valid", 32'(vcnt), 32'd0);
    $display("txn midrst: 1111+2222 aborted at k=2");
    run_txn(16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0, 0, "after reset 8+8");

    // WIDTH=4 instance
    sel4 = 1'b1;
    @(negedge clk);
    run_txn(16'h000F, 16'h0001, 1'b1, 16'h0001, 1'b1, 0, "w4 F+1+1");
    run_txn(16'h0007, 16'h0008, 1'b0, 16'h000F, 1'b0, 2, "w4 7+8");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
